// File: rtl/cbb_rs_backward.sv
// Backward (ready-path) register slice with a one-entry skid buffer.
// slv_o_ready comes straight from a flop, so the downstream ready never reaches
// the upstream ready combinationally. A beat arriving while downstream stalls
// is parked in the skid register and replayed before new beats are accepted.
module cbb_rs_backward #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    slv_i_valid,
  input  logic [P_DATA_WIDTH-1:0] slv_i_data,
  output logic                    slv_o_ready,
  output logic                    mst_o_valid,
  output logic [P_DATA_WIDTH-1:0] mst_o_data,
  input  logic                    mst_i_ready,
  output logic                    o_skid_full,
  output logic [P_CNT_WIDTH-1:0]  o_skid_cnt
);

  localparam logic [1:0] StHold = 2'd0;
  localparam logic [1:0] StPass = 2'd1;
  localparam logic [1:0] StSkid = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    ready_q;
  logic [P_DATA_WIDTH-1:0] skid_q;
  logic [P_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    capture;

  // A valid beat seen in PASS while downstream is stalled must be parked.
  always_comb begin
    capture = (state_q == StPass) && slv_i_valid && !mst_i_ready;
  end

  // Next-state selection: HOLD only leaves on the first edge out of reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHold:  state_d = StPass;
      StPass:  state_d = capture ? StSkid : StPass;
      StSkid:  state_d = mst_i_ready ? StPass : StSkid;
      default: state_d = StHold;
    endcase
  end

  // Saturating count of skid captures; never wraps from all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && (cnt_q != {P_CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + P_CNT_WIDTH'(1);
    end
  end

  // State, registered ready, and statistics; ready mirrors the next state so it
  // is a pure flop output yet always agrees with the state register.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      state_q <= StHold;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StPass);
      cnt_q   <= cnt_d;
    end
  end

  // Skid payload loads only on capture so it stays quiet otherwise.
  always_ff @(posedge i_clk or posedge i_rstn) begin
    if (i_rstn) begin
      skid_q <= '0;
    end else if (capture) begin
      skid_q <= slv_i_data;
    end
  end

  // Output steering: pass-through in PASS, replay skid in SKID, idle in HOLD.
  always_comb begin
    mst_o_valid = 1'b0;
    mst_o_data  = '0;
    case (state_q)
      StPass: begin
        mst_o_valid = slv_i_valid;
        mst_o_data  = slv_i_data;
      end
      StSkid: begin
        mst_o_valid = 1'b1;
        mst_o_data  = skid_q;
      end
      default: begin
        mst_o_valid = 1'b0;
        mst_o_data  = '0;
      end
    endcase
  end

  assign slv_o_ready = ready_q;
  assign o_skid_full = (state_q == StSkid);
  assign o_skid_cnt  = cnt_q;

endmodule

// File: doc/cbb_rs_backward.md
Name: cbb_rs_backward

Overview:
- Backward (ready-path) register slice: the counterpart to the team's forward register slice CBB.
- Breaks the combinational mst_i_ready -> slv_o_ready timing path by registering slv_o_ready.
- Uses a one-entry skid buffer, so no beat is lost when downstream deasserts ready.
- Sits between any valid/ready producer (slv side) and consumer (mst side); zero-latency pass-through when the skid is empty.

Parameters:
- P_DATA_WIDTH, 32, payload width in bits.
- P_CNT_WIDTH, 16, width of the saturating skid-capture statistics counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  reset; asynchronous, active-high (asserted when 1).
- slv_i_valid  input  1  upstream beat valid.
- slv_i_data  input  P_DATA_WIDTH  upstream payload.
- slv_o_ready  output  1  upstream ready; driven directly by a flop.
- mst_o_valid  output  1  downstream beat valid.
- mst_o_data  output  P_DATA_WIDTH  downstream payload.
- mst_i_ready  input  1  downstream ready.
- o_skid_full  output  1  1 while the skid register holds a beat (state SKID).
- o_skid_cnt  output  P_CNT_WIDTH  number of skid captures since reset; saturates at all-ones.

Behaviour:
- Reset is asynchronous, active-high on i_rstn, clock i_clk. While i_rstn=1:
  - state=HOLD, slv_o_ready=0, mst_o_valid=0, mst_o_data=0, o_skid_full=0, o_skid_cnt=0, skid data=0.
- State HOLD (entered only via reset):
  - slv_o_ready=0, mst_o_valid=0.
  - First rising edge after i_rstn falls -> PASS.
- State PASS:
  - slv_o_ready=1, mst_o_valid=slv_i_valid, mst_o_data=slv_i_data (combinational, 0-cycle latency).
  - slv_i_valid=1 and mst_i_ready=1: beat forwarded in the same cycle; stay PASS.
  - slv_i_valid=1 and mst_i_ready=0: beat captured into the skid register; next state SKID, with slv_o_ready=0 from the next cycle. o_skid_cnt increments by 1 unless already all-ones.
  - slv_i_valid=0: no transfer; stay PASS.
- State SKID:
  - slv_o_ready=0, mst_o_valid=1, mst_o_data=skid data (stable until accepted).
  - mst_i_ready=1: skid beat delivered; next state PASS, slv_o_ready=1 next cycle. The upstream beat is NOT accepted this cycle, because slv_o_ready was 0.
  - mst_i_ready=0: hold state and data.
- Handshake rules:
  - Transfer on slv side = slv_i_valid & slv_o_ready; on mst side = mst_o_valid & mst_i_ready.
  - Upstream must hold valid/data stable while not accepted. The block never drops or duplicates a beat, and preserves order.
- Throughput:
  - 1 beat/cycle while downstream stays ready.
  - After each stall, one bubble cycle on the slv side (registered ready) while the skid drains.
- Combinational paths:
  - No path from mst_i_ready to slv_o_ready.
  - The slv_i -> mst_o path exists only in PASS (accepted cost of this slice type).
- Skid data register loads only on the capture condition; it does not toggle otherwise.
- Reset mid-operation:
  - A beat held in SKID is discarded; mst_o_valid drops asynchronously with reset.
  - Upstream sees slv_o_ready=0 and must re-present the beat after reset.
- Counter: o_skid_cnt is saturating; no wrap from all-ones to 0.

Test Plan:
- Reset release: i_rstn 1->0 -> slv_o_ready=0 on the first edge, 1 after the next edge; mst_o_valid=0 throughout HOLD; o_skid_cnt=0.
- Streaming: mst_i_ready=1, send 0x11..0x18 on consecutive cycles -> identical beats on mst side in the same cycles, o_skid_cnt=0, slv_o_ready stays 1.
- Single stall: send 0xA5A5A5A5 with mst_i_ready=0 -> next cycle o_skid_full=1, slv_o_ready=0, mst_o_data=0xA5A5A5A5 held. Raise mst_i_ready after 3 cycles -> beat delivered once, slv_o_ready=1 on the following cycle, o_skid_cnt=1.
- Random backpressure: 20 random beats with random delays of 1-10 cycles, and mst_i_ready toggled randomly over periods of 1-10 cycles -> scoreboard receives all 20 in order, no duplicates; o_skid_cnt equals the number of capture events.
- Reset in SKID: capture 0xDEADBEEF, assert i_rstn for 2 cycles -> mst_o_valid=0 immediately, o_skid_full=0, o_skid_cnt=0; 0xDEADBEEF never appears on the mst side.
- Saturation: P_CNT_WIDTH=2, force 5 stall captures -> o_skid_cnt reads 1,2,3,3,3.
